ofm_pool_unit: RTL
==================

# ofm_pool_unit

Output post-processing stage placed directly downstream of the convolution core. It consumes the raw DATA_WIDTH-bit signed convolution sums in raster order and applies four steps: bias add, ReLU, requantization to OFM_WIDTH unsigned, and 2x2 stride-2 max-pooling. Pooled activations are emitted for write-back as the next layer's IFM stream.

## Interface
- DATA_WIDTH, 20, width of incoming signed convolution sum and bias
- OFM_WIDTH, 8, width of unsigned output activation
- MAX_COLS, 16, maximum conv-output row length; line buffer depth is MAX_COLS/2
- DIM_WIDTH, 5, width of cfg_cols/cfg_rows
- SHIFT_WIDTH, 5, width of cfg_shift
- clk1  input  1  sole clock, all logic on posedge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; latches cfg_* and begins a map when in IDLE
- cfg_cols  input  DIM_WIDTH  conv-output columns (2..MAX_COLS)
- cfg_rows  input  DIM_WIDTH  conv-output rows (>=2)
- cfg_shift  input  SHIFT_WIDTH  arithmetic right shift for requantization (0..DATA_WIDTH)
- bias  input  DATA_WIDTH  signed bias added to every sum
- in_valid  input  1  data_in valid this cycle; at most one sample per cycle, no backpressure
- data_in  input  DATA_WIDTH  signed convolution sum
- out_valid  output  1  data_out valid, one-cycle pulse per pooled value
- data_out  output  OFM_WIDTH  pooled activation
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse at end of map

## Operation
- FSM: IDLE -> RUN on start; RUN -> DONE after cfg_cols*cfg_rows accepted samples and pipeline drained; DONE -> IDLE unconditionally (done=1 for that one cycle).
- In IDLE/DONE, in_valid is ignored. In RUN, start is ignored and the latched cfg_* apply. If cfg_cols<2 or cfg_rows<2 at start: go straight to DONE next cycle with no output.
- Stage 1, per accepted sample: s = data_in + bias at DATA_WIDTH+1 bits signed. If s<0 then r=0, else r = s >>> cfg_shift. Saturate r to 2^OFM_WIDTH-1. Register the result as q.
- Column counter c and row counter r_idx wrap at cfg_cols / cfg_rows.
- Stage 2, horizontal: on even c, hold q. On odd c, h = max(held, q).
- Stage 2, vertical: on even r_idx, write h to line buffer[c/2]. On odd r_idx, data_out = max(h, buffer[c/2]) and out_valid pulses.
- Odd cfg_cols: last column of every row is consumed but discarded. Odd cfg_rows: last row is consumed but discarded (floor pooling).
- Line buffer is not cleared between maps; every entry is written before it is read.

## Timing
- Reset values: out_valid=0, data_out=0, busy=0, done=0, FSM=IDLE, counters=0, held/q=0.
- Latency: sample accepted at edge t (odd col, odd row) gives out_valid at edge t+2.
- done pulses at edge t+3, where t is the edge of the final accepted sample. busy falls at the same edge.
- Full-rate input is sustained (no bubbles required). A gap in in_valid stalls counters only; pipeline registers still advance, and no out_valid is produced for the gap.
- rst_n asserted mid-map: immediate return to reset values. The partial map is abandoned; the next start begins clean.

## Configuration
- OFM_ROUND_EN defined: round-half-up before shift. When cfg_shift>0, add 1<<(cfg_shift-1) to non-negative s before shifting; the add is performed at DATA_WIDTH+1 bits with no overflow.
- OFM_ROUND_EN undefined: truncating shift only.

## Test plan
- cols=4, rows=2, shift=0, bias=0; rows {1,5,3,2},{4,0,7,9} -> out_valid twice, data_out 5 then 9. done 3 cycles after last input.
- bias=-10, shift=0, 2x2 map of all 3 -> single output 0 (ReLU).
- 2x2 map of 1000 with shift=2 -> 250; 2x2 map of 2000 with shift=2 -> 255 (saturation). Negative data_in=-524288 -> 0 with no wrap.
- 2x2 map of 6 with shift=2 -> 2 with OFM_ROUND_EN, 1 without.
- cols=5, rows=3, values = index 0..14, shift=0 -> outputs 6 then 8; 15 samples consumed; then done.
- Start map cols=4 rows=4, assert rst_n low after 6 samples -> all outputs at reset values. New start with the first test's stimulus -> 5, 9.

Source files
------------

// File: rtl/ofm_pool_unit.sv
// Conv-output post-processing: bias + ReLU + requantize + 2x2/2 max-pool.
// Optional OFM_ROUND_EN macro selects round-half-up requantization.
module ofm_pool_unit #(
    parameter int DATA_WIDTH  = 20,
    parameter int OFM_WIDTH   = 8,
    parameter int MAX_COLS    = 16,
    parameter int DIM_WIDTH   = 5,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                   clk1,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [DIM_WIDTH-1:0]   cfg_cols,
    input  logic [DIM_WIDTH-1:0]   cfg_rows,
    input  logic [SHIFT_WIDTH-1:0] cfg_shift,
    input  logic [DATA_WIDTH-1:0]  bias,
    input  logic                   in_valid,
    input  logic [DATA_WIDTH-1:0]  data_in,
    output logic                   out_valid,
    output logic [OFM_WIDTH-1:0]   data_out,
    output logic                   busy,
    output logic                   done
);
    localparam int BUF_DEPTH = MAX_COLS / 2;
    localparam int IDX_W     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int STAGES    = 2;
    localparam logic [DATA_WIDTH:0] SAT = (DATA_WIDTH+1)'((1 << OFM_WIDTH) - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [DIM_WIDTH-1:0]   cols_q, cols_d, rows_q, rows_d, c_q, c_d, r_q, r_d;
    logic [SHIFT_WIDTH-1:0] shift_q, shift_d;
    logic                   fed_q, fed_d;
    logic [STAGES:0]        last_pipe_q, last_pipe_d;
    logic [OFM_WIDTH-1:0]   q_q, q_d, held_q, held_d, h_q, h_d, data_out_q, data_out_d;
    logic                   v1_q, v1_d, codd1_q, codd1_d, rodd1_q, rodd1_d;
    logic                   v2_q, v2_d, rodd2_q, rodd2_d, out_valid_q, out_valid_d;
    logic [IDX_W-1:0]       idx1_q, idx1_d, idx2_q, idx2_d;
    logic [OFM_WIDTH-1:0]   lbuf_q [BUF_DEPTH];

    logic                   accept, last_acc, col_wrap;
    logic [DATA_WIDTH:0]    sum, s_adj, shifted, rnd;
    logic [OFM_WIDTH-1:0]   q_sat, rd;

    // Requantization: sum is sign-extended, then handled as unsigned once non-negative
    always_comb begin
        sum = {data_in[DATA_WIDTH-1], data_in} + {bias[DATA_WIDTH-1], bias};
        rnd = '0;
`ifdef OFM_ROUND_EN
        if (shift_q != '0 && !sum[DATA_WIDTH])
            rnd = (DATA_WIDTH+1)'(1) << (shift_q - SHIFT_WIDTH'(1));
`endif
        s_adj   = sum[DATA_WIDTH] ? '0 : (sum + rnd);
        shifted = s_adj >> shift_q;
        q_sat   = (shifted > SAT) ? {OFM_WIDTH{1'b1}} : shifted[OFM_WIDTH-1:0];
    end

    always_comb begin
        state_d  = state_q;
        cols_d   = cols_q;
        rows_d   = rows_q;
        shift_d  = shift_q;
        c_d      = c_q;
        r_d      = r_q;
        fed_d    = fed_q;
        accept   = (state_q == RUN) && in_valid && !fed_q;
        col_wrap = (c_q == cols_q - DIM_WIDTH'(1));
        last_acc = accept && col_wrap && (r_q == rows_q - DIM_WIDTH'(1));
        if (accept) begin
            c_d = col_wrap ? '0 : c_q + DIM_WIDTH'(1);
            if (col_wrap)
                r_d = (r_q == rows_q - DIM_WIDTH'(1)) ? '0 : r_q + DIM_WIDTH'(1);
            if (last_acc)
                fed_d = 1'b1;
        end
        case (state_q)
            IDLE: if (start) begin
                cols_d  = cfg_cols;
                rows_d  = cfg_rows;
                shift_d = cfg_shift;
                c_d     = '0;
                r_d     = '0;
                fed_d   = 1'b0;
                state_d = (cfg_cols < DIM_WIDTH'(2) || cfg_rows < DIM_WIDTH'(2)) ? DONE : RUN;
            end
            RUN:  if (last_pipe_q[STAGES]) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        last_pipe_d = {last_pipe_q[STAGES-1:0], last_acc};
    end

    // Pool datapath: stage 1 = q, stage 2 = horizontal max, stage 3 = vertical max / line buffer
    always_comb begin
        q_d         = accept ? q_sat : q_q;
        v1_d        = accept;
        codd1_d     = accept ? c_q[0] : codd1_q;
        rodd1_d     = accept ? r_q[0] : rodd1_q;
        idx1_d      = accept ? c_q[IDX_W:1] : idx1_q;
        held_d      = (v1_q && !codd1_q) ? q_q : held_q;
        v2_d        = v1_q && codd1_q;
        h_d         = v2_d ? ((held_q > q_q) ? held_q : q_q) : h_q;
        rodd2_d     = v2_d ? rodd1_q : rodd2_q;
        idx2_d      = v2_d ? idx1_q : idx2_q;
        rd          = lbuf_q[idx2_q];
        out_valid_d = v2_q && rodd2_q;
        data_out_d  = out_valid_d ? ((h_q > rd) ? h_q : rd) : data_out_q;
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cols_q      <= '0;
            rows_q      <= '0;
            shift_q     <= '0;
            c_q         <= '0;
            r_q         <= '0;
            fed_q       <= 1'b0;
            last_pipe_q <= '0;
            q_q         <= '0;
            v1_q        <= 1'b0;
            codd1_q     <= 1'b0;
            rodd1_q     <= 1'b0;
            idx1_q      <= '0;
            held_q      <= '0;
            h_q         <= '0;
            v2_q        <= 1'b0;
            rodd2_q     <= 1'b0;
            idx2_q      <= '0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            cols_q      <= cols_d;
            rows_q      <= rows_d;
            shift_q     <= shift_d;
            c_q         <= c_d;
            r_q         <= r_d;
            fed_q       <= fed_d;
            last_pipe_q <= last_pipe_d;
            q_q         <= q_d;
            v1_q        <= v1_d;
            codd1_q     <= codd1_d;
            rodd1_q     <= rodd1_d;
            idx1_q      <= idx1_d;
            held_q      <= held_d;
            h_q         <= h_d;
            v2_q        <= v2_d;
            rodd2_q     <= rodd2_d;
            idx2_q      <= idx2_d;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
        end
    end

    // Line buffer is never cleared; the even row of each pair fills it before the odd row reads
    always_ff @(posedge clk1) begin
        if (v2_q && !rodd2_q)
            lbuf_q[idx2_q] <= h_q;
    end

    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
endmodule
